stream_mux_nx1: RTL and testbench

//   Registered CH-to-1 stream multiplexer with valid/ready handshake, the successor to
//   the plain combinational 2:1 data mux. Used in the NTT datapath to merge coefficient

---
 rtl/stream_mux_nx1_if.sv | 30 +++
 rtl/stream_mux_nx1.sv | 113 +++++++++++
 tb/tb_stream_mux_nx1.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_mux_nx1_if.sv
// Handshake bundle for stream_mux_nx1: CH input lanes, one registered output lane.
// The master drives the inputs and out_ready. The slave (the mux) drives in_ready and the output lane.
interface stream_mux_nx1_if #(
  parameter int W  = 32,
  parameter int CH = 4
);
  localparam int SELW = (CH > 1) ? $clog2(CH) : 1;

  logic              mode;
  logic [SELW-1:0]   sel;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_last;
  logic [CH*W-1:0]   in_data;
  logic [CH-1:0]     in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic              out_last;
  logic [SELW-1:0]   out_ch;
  logic              out_ready;

  modport master (
    output mode, sel, in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_ch
  );

  modport slave (
    input  mode, sel, in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_ch
  );
endinterface

// File: rtl/stream_mux_nx1.sv
// Registered CH:1 stream mux (explicit select or round-robin) with burst locking on in_last.
// Latency is 1 cycle. A full output register that is not accepted holds its word and drives in_ready to 0.
module stream_mux_nx1 #(
  parameter int W  = 32,
  parameter int CH = 4
) (
  input logic             clk,
  input logic             rst,
  stream_mux_nx1_if.slave bus
);
  localparam int SELW = (CH > 1) ? $clog2(CH) : 1;

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic            out_last_q,  out_last_d;
  logic [SELW-1:0] out_ch_q,    out_ch_d;
  logic            lock_q,      lock_d;
  logic [SELW-1:0] lock_ch_q,   lock_ch_d;
  logic [SELW-1:0] rr_ptr_q,    rr_ptr_d;

  logic            load;
  logic            grant_vld;
  logic [SELW-1:0] grant_ch;
  logic [CH-1:0]   in_ready;
  logic            xfer;
  logic            xfer_last;
  int              idx;

  assign load = !out_valid_q || bus.out_ready;

  // Round-robin scan runs backwards so the last hit is the first channel at or after rr_ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = 0;
    if (lock_q) begin
      grant_vld = 1'b1;
      grant_ch  = lock_ch_q;
    end else if (!bus.mode) begin
      if (int'(bus.sel) < CH) begin
        grant_vld = 1'b1;
        grant_ch  = bus.sel;
      end
    end else begin
      for (int k = CH - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr_q) + k) % CH;
        if (bus.in_valid[idx]) begin
          grant_vld = 1'b1;
          grant_ch  = SELW'(idx);
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CH; i++) begin
      in_ready[i] = !rst && load && grant_vld && (int'(grant_ch) == i);
    end
  end

  assign xfer      = |(in_ready & bus.in_valid);
  assign xfer_last = bus.in_last[grant_ch];

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = xfer;
    end
    if (xfer) begin
      out_data_d = bus.in_data[grant_ch*W +: W];
      out_last_d = xfer_last;
      out_ch_d   = grant_ch;
      lock_d     = !xfer_last;
      lock_ch_d  = grant_ch;
      if (bus.mode && xfer_last) begin
        rr_ptr_d = (int'(grant_ch) == CH - 1) ? '0 : grant_ch + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_stream_mux_nx1.sv
// Bench for stream_mux_nx1: directed scenarios plus random traffic against a transaction-level model.
module tb_stream_mux_nx1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_mux_nx1_if #(.W(32), .CH(4)) bus4 ();
  stream_mux_nx1_if #(.W(8),  .CH(3)) bus3 ();

  stream_mux_nx1 #(.W(32), .CH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  stream_mux_nx1 #(.W(8),  .CH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int checks = 0;
  int errors = 0;

  // Reference state: burst owner, round-robin start, and the expected output register.
  bit          m_lock;
  int          m_lock_ch;
  int          m_rr;
  bit          m_ov;
  logic [31:0] m_od;
  bit          m_ol;
  int          m_oc;
  logic [3:0]  seen_rdy;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_lock_ch = 0; m_rr = 0;
    m_ov = 0; m_od = '0; m_ol = 0; m_oc = 0;
  endtask

  task automatic set_ch(input int c, input logic [31:0] d, input bit last, input bit vld);
    bus4.in_data[c*32 +: 32] = d;
    bus4.in_last[c] = last;
    bus4.in_valid[c] = vld;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus4.in_valid = '0;
  endtask

  // Inputs must already be driven (after a negedge). Checks in_ready, steps one edge, checks outputs.
  task automatic cycle();
    int g;
    bit ok;
    bit load, xfer, lst;
    logic [3:0] exp_rdy;
    #1;
    g = 0;
    ok = 0;
    if (m_lock) begin
      g = m_lock_ch; ok = 1;
    end else if (!bus4.mode) begin
      g = int'(bus4.sel); ok = (g < 4);
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (!ok && bus4.in_valid[(m_rr + k) % 4]) begin
          g = (m_rr + k) % 4; ok = 1;
        end
      end
    end
    load = !m_ov || bus4.out_ready;
    exp_rdy = (ok && load) ? (4'b0001 << g) : 4'b0000;
    seen_rdy = bus4.in_ready;
    check_eq("in_ready", bus4.in_ready, exp_rdy);
    check_eq("rdy_onehot0", $onehot0(bus4.in_ready), 1);
    xfer = ok && load && bus4.in_valid[g];
    lst = bus4.in_last[g];
    if (xfer) begin
      m_ov = 1; m_od = bus4.in_data[g*32 +: 32]; m_ol = lst; m_oc = g;
      m_lock = !lst; m_lock_ch = g;
      if (bus4.mode && lst) m_rr = (g + 1) % 4;
    end else if (load) begin
      m_ov = 0;
    end
    @(posedge clk);
    #1;
    check_eq("out_valid", bus4.out_valid, m_ov);
    check_eq("out_data", bus4.out_data, m_od);
    check_eq("out_last", bus4.out_last, m_ol);
    check_eq("out_ch", bus4.out_ch, m_oc[1:0]);
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};
    model_reset();
    bus4.mode = 1'b1; bus4.sel = '0; bus4.in_valid = 4'hF; bus4.in_last = 4'hF;
    bus4.in_data = '0; bus4.out_ready = 1'b1;
    bus3.mode = 1'b0; bus3.sel = '0; bus3.in_valid = '0; bus3.in_last = 3'h7;
    bus3.in_data = 24'h332211; bus3.out_ready = 1'b1;

    // Reset holds in_ready low even with every channel valid.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", bus4.in_ready, 4'h0);
    check_eq("rst_out_valid", bus4.out_valid, 1'b0);
    check_eq("rst_out_data", bus4.out_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) set_ch(c, 32'hC0 + c, 1'b1, 1'b1);
    cycle();
    check_eq("rst_first_grant", bus4.out_ch, 2'd0);

    // Explicit select, ch2 burst of three.
    do_reset();
    bus4.mode = 1'b0; bus4.sel = 2'd2;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      set_ch(2, 32'h10 + k, k == 2, 1'b1);
      cycle();
      check_eq("sel2_data", bus4.out_data, 32'h10 + k);
      check_eq("sel2_ch", bus4.out_ch, 2'd2);
    end

    // Round-robin with single-word bursts.
    do_reset();
    bus4.mode = 1'b1;
    for (int c = 0; c < 4; c++) set_ch(c, 32'hA0 + c, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      cycle();
      check_eq("rr_order", bus4.out_ch, order[k][1:0]);
    end

    // Round-robin with ch1 holding a 3-word burst.
    do_reset();
    bus4.mode = 1'b1;
    set_ch(0, 32'hB0, 1'b1, 1'b1);
    cycle();
    @(negedge clk);
    set_ch(2, 32'hB2, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      set_ch(1, 32'hB10 + k, k == 2, 1'b1);
      cycle();
      check_eq("burst_ch1", bus4.out_ch, 2'd1);
    end
    @(negedge clk);
    cycle();
    check_eq("burst_then_ch2", bus4.out_ch, 2'd2);

    // Backpressure.
    do_reset();
    bus4.mode = 1'b0; bus4.sel = 2'd0;
    set_ch(0, 32'h55, 1'b1, 1'b1);
    cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus4.out_ready = 1'b0;
      set_ch(0, 32'h66, 1'b1, 1'b1);
      cycle();
      check_eq("bp_rdy", seen_rdy, 4'h0);
      check_eq("bp_hold", bus4.out_data, 32'h55);
    end
    @(negedge clk);
    bus4.out_ready = 1'b1;
    cycle();
    check_eq("bp_release_rdy", seen_rdy, 4'h1);
    check_eq("bp_release_data", bus4.out_data, 32'h66);

    // Out-of-range select on the 3-channel instance.
    @(negedge clk);
    bus3.sel = 2'd3; bus3.in_valid = 3'h7;
    #1;
    check_eq("oor_rdy", bus3.in_ready, 3'h0);
    @(posedge clk); #1;
    check_eq("oor_valid", bus3.out_valid, 1'b0);
    @(negedge clk);
    bus3.sel = 2'd2;
    #1;
    check_eq("sel2_ch3_rdy", bus3.in_ready, 3'h4);
    @(posedge clk); #1;
    check_eq("sel2_ch3_data", bus3.out_data, 8'h33);

    // Reset in the middle of a ch1 burst, then follow the new select.
    do_reset();
    bus4.mode = 1'b0; bus4.sel = 2'd1;
    set_ch(1, 32'hD1, 1'b0, 1'b1);
    cycle();
    @(negedge clk);
    bus4.sel = 2'd3;
    set_ch(3, 32'hD3, 1'b1, 1'b1);
    cycle();
    check_eq("lock_holds", seen_rdy, 4'h2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_valid", bus4.out_valid, 1'b0);
    check_eq("midrst_rdy", bus4.in_ready, 4'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    check_eq("after_rst_grant", seen_rdy, 4'h8);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(15) == 0) bus4.mode = $urandom_range(1);
      bus4.sel = 2'($urandom_range(3));
      bus4.out_ready = ($urandom_range(3) != 0);
      for (int c = 0; c < 4; c++)
        set_ch(c, $urandom, $urandom_range(2) == 0, $urandom_range(1) == 1);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
